// File: rtl/csi_rx_byte_align.sv
// Purpose : per-lane HS byte aligner; finds the sync byte at any of 8 bit offsets, locks it, streams aligned bytes.
// Latency : first aligned byte (the one after the sync) is valid 2 cycles after the match cycle; all outputs registered.
// Backpr. : none; the lane cannot be stalled, downstream must take every aligned_valid byte.
//
// Ports:
//   byte_clock    - SDR byte clock, sole clock
//   reset         - synchronous, active-high
//   in_hs         - lane is in HS mode
//   packet_done   - 1-cycle pulse, current packet ended (packet handler counts bytes)
//   deser_byte    - raw ISERDES word, bit0 earliest on the wire
//   aligned_byte  - aligned data byte, holds when aligned_valid=0
//   aligned_valid - aligned_byte valid this cycle
//   locked        - offset locked
//   bit_offset    - locked offset, cleared only by reset
//   sync_timeout  - 1-cycle pulse, search expired without a sync
module csi_rx_byte_align #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hB8,
  parameter int unsigned SETTLE_CYC     = 2,
  parameter int unsigned SEARCH_TIMEOUT = 64
) (
  input  logic       byte_clock,
  input  logic       reset,
  input  logic       in_hs,
  input  logic       packet_done,
  input  logic [7:0] deser_byte,
  output logic [7:0] aligned_byte,
  output logic       aligned_valid,
  output logic       locked,
  output logic [2:0] bit_offset,
  output logic       sync_timeout
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_SEARCH  = 3'd2;
  localparam logic [2:0] ST_LOCKED  = 3'd3;
  localparam logic [2:0] ST_WAIT_LP = 3'd4;

  localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYC - 1);
  localparam logic [9:0] SEARCH_LAST = 10'(SEARCH_TIMEOUT - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [9:0]  cnt;
  logic [9:0]  cnt_nxt;
  logic [7:0]  d1;
  logic [7:0]  d2;
  logic [15:0] window;
  logic [7:0]  match;
  logic        match_any;
  logic [2:0]  match_off;
  logic        lock_now;
  logic        timeout_nxt;
  logic        stream;

  // d2 is the older byte, so it occupies the low (earlier) half of the window.
  assign window = {d1, d2};

  always_comb begin
    match = '0;
    for (int o = 0; o < 8; o++) begin
      match[o] = (window[o +: 8] == SYNC_BYTE);
    end
  end

  assign match_any = |match;

  // Walk from the top down so the lowest matching offset is the one left standing.
  always_comb begin
    match_off = 3'd0;
    for (int o = 7; o >= 0; o--) begin
      if (match[o]) begin
        match_off = 3'(o);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    lock_now    = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_hs) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
        end
      end
      ST_SETTLE: begin
        // Window still holds pre-HS data here; matches are deliberately ignored.
        if (cnt == SETTLE_LAST) begin
          state_nxt = ST_SEARCH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 10'd1;
        end
      end
      ST_SEARCH: begin
        if (match_any) begin
          state_nxt = ST_LOCKED;
          lock_now  = 1'b1;
        end else if (cnt == SEARCH_LAST) begin
          state_nxt   = ST_WAIT_LP;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 10'd1;
        end
      end
      ST_LOCKED: begin
        if (packet_done) begin
          state_nxt = ST_WAIT_LP;
        end
      end
      ST_WAIT_LP: begin
        // Parked until the lane leaves HS; no re-search inside one burst.
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // HS exit overrides match, timeout and packet_done.
    if ((state != ST_IDLE) && !in_hs) begin
      state_nxt   = ST_IDLE;
      cnt_nxt     = '0;
      lock_now    = 1'b0;
      timeout_nxt = 1'b0;
    end
  end

  // Only stream while staying locked, so packet_done and HS exit drop valid on the same edge.
  assign stream = (state == ST_LOCKED) && (state_nxt == ST_LOCKED);

  always_ff @(posedge byte_clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      d1            <= '0;
      d2            <= '0;
      aligned_byte  <= '0;
      aligned_valid <= 1'b0;
      locked        <= 1'b0;
      bit_offset    <= '0;
      sync_timeout  <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      d1            <= deser_byte;
      d2            <= d1;
      sync_timeout  <= timeout_nxt;
      locked        <= (state_nxt == ST_LOCKED);
      aligned_valid <= stream;
      if (lock_now) begin
        bit_offset <= match_off;
      end
      if (stream) begin
        aligned_byte <= window[bit_offset +: 8];
      end
    end
  end

endmodule

// File: tb/tb_csi_rx_byte_align.sv
module tb_csi_rx_byte_align;

  localparam logic [7:0] SYNC    = 8'hB8;
  localparam int         SETTLE  = 2;
  localparam int         TIMEOUT = 64;

  logic       byte_clock = 1'b0;
  logic       reset;
  logic       in_hs;
  logic       packet_done;
  logic [7:0] deser_byte;
  logic [7:0] aligned_byte;
  logic       aligned_valid;
  logic       locked;
  logic [2:0] bit_offset;
  logic       sync_timeout;

  always #5 byte_clock = ~byte_clock;

  csi_rx_byte_align #(
    .SYNC_BYTE     (SYNC),
    .SETTLE_CYC    (SETTLE),
    .SEARCH_TIMEOUT(TIMEOUT)
  ) dut (
    .byte_clock   (byte_clock),
    .reset        (reset),
    .in_hs        (in_hs),
    .packet_done  (packet_done),
    .deser_byte   (deser_byte),
    .aligned_byte (aligned_byte),
    .aligned_valid(aligned_valid),
    .locked       (locked),
    .bit_offset   (bit_offset),
    .sync_timeout (sync_timeout)
  );

  typedef struct packed {
    logic       rst;
    logic       hs;
    logic       pd;
    logic [7:0] din;
    logic       vld;
    logic       lck;
    logic [2:0] off;
    logic [7:0] dout;
    logic       to;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic rst, input logic hs, input logic pd, input logic [7:0] din,
                              input logic vld, input logic lck, input logic [2:0] off,
                              input logic [7:0] dout, input logic to);
    vec_t v;
    v.rst = rst; v.hs = hs; v.pd = pd; v.din = din;
    v.vld = vld; v.lck = lck; v.off = off; v.dout = dout; v.to = to;
    return v;
  endfunction

  // Inputs change 1 time unit after the active edge; outputs are read at the same point.
  task automatic drive(input logic r, input logic h, input logic p, input logic [7:0] b);
    reset       = r;
    in_hs       = h;
    packet_done = p;
    deser_byte  = b;
    @(posedge byte_clock);
    #1;
  endtask

  task automatic check_all(input string nm, input logic vld, input logic lck, input logic [2:0] off,
                           input logic [7:0] dout, input logic to);
    n_vec++;
    if ({aligned_valid, locked, bit_offset, aligned_byte, sync_timeout} !== {vld, lck, off, dout, to}) begin
      n_err++;
      $display("FAIL %s: got vld=%b lck=%b off=%0d byte=%h to=%b, want vld=%b lck=%b off=%0d byte=%h to=%b",
               nm, aligned_valid, locked, bit_offset, aligned_byte, sync_timeout, vld, lck, off, dout, to);
    end
  endtask

  task automatic check_val(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Reference model: tracks the burst as a timeline (edge of HS acceptance, lock edge,
  // burst finished) and derives outputs from elapsed cycles and the two most recent bytes.
  logic [7:0] m_d1, m_d2;
  logic       m_active, m_have, m_done;
  int         m_t, m_t0;
  logic       e_vld, e_lck, e_to;
  logic [2:0] e_off;
  logic [7:0] e_byte;

  task automatic model_step(input logic r, input logic h, input logic p, input logic [7:0] b);
    logic [15:0] win;
    logic [15:0] sh;
    int          found;
    int          s;
    win   = {m_d1, m_d2};
    found = -1;
    e_vld = 1'b0;
    e_to  = 1'b0;
    m_t++;
    if (r) begin
      m_active = 1'b0; m_have = 1'b0; m_done = 1'b0;
      e_off = 3'd0; e_byte = 8'h00; e_lck = 1'b0;
      m_d1 = 8'h00; m_d2 = 8'h00;
    end else begin
      if (!m_active) begin
        if (h) begin
          m_active = 1'b1; m_t0 = m_t; m_have = 1'b0; m_done = 1'b0;
        end
      end else if (!h) begin
        m_active = 1'b0;
      end else if (!m_done) begin
        if (m_have) begin
          if (p) begin
            m_done = 1'b1;
          end else begin
            sh     = win >> e_off;
            e_vld  = 1'b1;
            e_byte = sh[7:0];
          end
        end else begin
          s = m_t - m_t0 - SETTLE - 1;  // search cycle index, negative while settling
          if (s >= 0) begin
            for (int o = 0; o < 8; o++) begin
              sh = win >> o;
              if (found < 0 && sh[7:0] == SYNC) found = o;
            end
            if (found >= 0) begin
              m_have = 1'b1;
              e_off  = 3'(found);
            end else if (s == TIMEOUT - 1) begin
              e_to   = 1'b1;
              m_done = 1'b1;
            end
          end
        end
      end
      e_lck = m_active && m_have && !m_done;
      m_d2  = m_d1;
      m_d1  = b;
    end
  endtask

  initial begin
    int         first_to;
    int         n_to;
    int         lock_seen;
    int         hs_left;
    logic       cur_hs;
    logic       r, p;
    logic [7:0] b;
    logic [15:0] v;
    int         o;
    logic [7:0] pend[$];

    reset = 1'b1; in_hs = 1'b0; packet_done = 1'b0; deser_byte = 8'h00;

    //              rst  hs  pd   din     vld  lck off dout   to
    // Offset 0: sync B8 then 12 34 56
    tbl.push_back(mk(1, 0, 0, 8'h00,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 0, 8'hB8,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 0, 8'h12,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 0, 8'h34,   0, 1, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 0, 8'h56,   1, 1, 0, 8'h12, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00,   1, 1, 0, 8'h34, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00,   1, 1, 0, 8'h56, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00,   0, 0, 0, 8'h56, 0));
    // Offset 3: {05,C0} puts B8 at bit 3 (offsets 0..2 give C0,E0,70); payload 2D 05 -> A0, A5
    tbl.push_back(mk(0, 1, 0, 8'h00,   0, 0, 0, 8'h56, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00,   0, 0, 0, 8'h56, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00,   0, 0, 0, 8'h56, 0));
    tbl.push_back(mk(0, 1, 0, 8'hC0,   0, 0, 0, 8'h56, 0));
    tbl.push_back(mk(0, 1, 0, 8'h05,   0, 0, 0, 8'h56, 0));
    tbl.push_back(mk(0, 1, 0, 8'h2D,   0, 1, 3, 8'h56, 0));
    tbl.push_back(mk(0, 1, 0, 8'h05,   1, 1, 3, 8'hA0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00,   1, 1, 3, 8'hA5, 0));
    // Packet end, then a sync inside the same burst must not relock
    tbl.push_back(mk(0, 1, 1, 8'h00,   0, 0, 3, 8'hA5, 0));
    tbl.push_back(mk(0, 1, 0, 8'hB8,   0, 0, 3, 8'hA5, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00,   0, 0, 3, 8'hA5, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00,   0, 0, 3, 8'hA5, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00,   0, 0, 3, 8'hA5, 0));
    // HS exit in the same cycle as a SEARCH match: no lock, offset unchanged
    tbl.push_back(mk(0, 1, 0, 8'h00,   0, 0, 3, 8'hA5, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00,   0, 0, 3, 8'hA5, 0));
    tbl.push_back(mk(0, 1, 0, 8'hB8,   0, 0, 3, 8'hA5, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00,   0, 0, 3, 8'hA5, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00,   0, 0, 3, 8'hA5, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00,   0, 0, 3, 8'hA5, 0));
    // After HS toggles, relock works again
    tbl.push_back(mk(0, 1, 0, 8'h00,   0, 0, 3, 8'hA5, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00,   0, 0, 3, 8'hA5, 0));
    tbl.push_back(mk(0, 1, 0, 8'hB8,   0, 0, 3, 8'hA5, 0));
    tbl.push_back(mk(0, 1, 0, 8'h3C,   0, 0, 3, 8'hA5, 0));
    tbl.push_back(mk(0, 1, 0, 8'h77,   0, 1, 0, 8'hA5, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00,   1, 1, 0, 8'h3C, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00,   1, 1, 0, 8'h77, 0));
    // Reset while streaming
    tbl.push_back(mk(1, 1, 0, 8'h00,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00,   0, 0, 0, 8'h00, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].hs, tbl[i].pd, tbl[i].din);
      check_all($sformatf("tbl%0d", i), tbl[i].vld, tbl[i].lck, tbl[i].off, tbl[i].dout, tbl[i].to);
    end

    // Settle masking: B8 sits in the window only during SETTLE, then zeros until timeout.
    drive(0, 1, 0, 8'hB8);
    drive(0, 1, 0, 8'h00);
    drive(0, 1, 0, 8'h00);
    check_all("settle_entry", 0, 0, 0, 8'h00, 0);
    first_to  = -1;
    n_to      = 0;
    lock_seen = 0;
    for (int i = 1; i <= 100; i++) begin
      // A sync arriving in WAIT_LP (same burst) must be ignored.
      b = (i == 80) ? 8'hB8 : ((i == 81) ? 8'h3C : 8'h00);
      drive(0, 1, 0, b);
      if (sync_timeout === 1'b1) begin
        n_to++;
        if (first_to < 0) first_to = i;
      end
      if (locked !== 1'b0 || aligned_valid !== 1'b0) lock_seen = 1;
    end
    check_val("timeout_after_search_cycles", first_to, TIMEOUT);
    check_val("timeout_pulse_count", n_to, 1);
    check_val("no_lock_settle_or_wait_lp", lock_seen, 0);
    drive(0, 0, 0, 8'h00);
    check_all("wait_lp_exit", 0, 0, 0, 8'h00, 0);

    // HS exit coinciding with packet_done while streaming.
    drive(0, 1, 0, 8'h00);
    drive(0, 1, 0, 8'h00);
    drive(0, 1, 0, 8'h00);
    drive(0, 1, 0, 8'hB8);
    drive(0, 1, 0, 8'h11);
    drive(0, 1, 0, 8'h22);
    check_all("relock_off0", 0, 1, 0, 8'h00, 0);
    drive(0, 1, 0, 8'h33);
    check_all("first_byte_11", 1, 1, 0, 8'h11, 0);
    drive(0, 0, 1, 8'h44);
    check_all("hs_exit_with_pd", 0, 0, 0, 8'h11, 0);

    // Randomized traffic against the model.
    drive(1, 0, 0, 8'h00);
    model_step(1, 0, 0, 8'h00);
    check_all("rand_reset", e_vld, e_lck, e_off, e_byte, e_to);
    hs_left = 0;
    cur_hs  = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (hs_left == 0) begin
        cur_hs  = ~cur_hs;
        hs_left = cur_hs ? int'($urandom_range(5, 150)) : int'($urandom_range(1, 6));
      end
      hs_left--;
      r = ($urandom_range(0, 299) == 0);
      p = ($urandom_range(0, 24) == 0);
      if (pend.size() == 0 && $urandom_range(0, 11) == 0) begin
        v = 16'($urandom);
        o = int'($urandom_range(0, 7));
        v[o +: 8] = SYNC;
        pend.push_back(v[7:0]);
        pend.push_back(v[15:8]);
      end
      if (pend.size() != 0) b = pend.pop_front();
      else                  b = 8'($urandom);
      model_step(r, cur_hs, p, b);
      drive(r, cur_hs, p, b);
      check_all($sformatf("rand%0d", c), e_vld, e_lck, e_off, e_byte, e_to);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
